// File: rtl/aes_pkg.sv
// Shared AES types and S-box tables for the SubBytes engine and its callers.
// Byte 0 of a state occupies bits [0:7] (ascending bit order).
package aes_pkg;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [0:127] aes_state_t;

  localparam int AES_BYTES = 16;

  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_RUN  = 2'd1,
    SB_DONE = 2'd2
  } aes_sb_state_e;

  localparam aes_byte_t AES_SBOX_FWD [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam aes_byte_t AES_SBOX_INV [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sub_bytes_iter_if.sv
// Block handshake bundle for the iterative SubBytes engine: input block side,
// result side and the busy indication. The engine uses the slave modport.
interface aes_sub_bytes_iter_if;
  import aes_pkg::*;

  logic       i_valid;
  logic       o_ready;
  aes_state_t i_data;
  logic       i_inverse;
  logic       o_valid;
  logic       i_ready;
  aes_state_t o_data;
  logic       o_busy;

  modport slave (
    input  i_valid, i_data, i_inverse, i_ready,
    output o_ready, o_valid, o_data, o_busy
  );

  modport master (
    output i_valid, i_data, i_inverse, i_ready,
    input  o_ready, o_valid, o_data, o_busy
  );
endinterface

// File: rtl/aes_sbox.sv
// Single-byte AES S-box, forward or inverse selected per call; purely combinational.
module aes_sbox
  import aes_pkg::*;
(
  input  aes_byte_t i_byte,
  input  logic      i_inverse,
  output aes_byte_t o_byte
);

  assign o_byte = i_inverse ? AES_SBOX_INV[i_byte] : AES_SBOX_FWD[i_byte];

endmodule

// File: rtl/aes_sub_bytes_iter.sv
// Iterative SubBytes/InvSubBytes: LANES S-boxes rewrite the 128-bit working
// register one chunk per cycle, with valid/ready on both sides and a sync clear.
module aes_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_clear,
  aes_sub_bytes_iter_if.slave    bus
);

  localparam int N       = AES_BYTES / LANES;
  localparam int CW      = (N > 1) ? $clog2(N) : 1;
  localparam int CHUNK_W = LANES * 8;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  aes_sb_state_e  state_q, state_d;
  aes_state_t     work_q, work_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           inv_q, inv_d;
  logic           ready_q, ready_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;

  logic [7:0]           chunk_base;
  logic [0:CHUNK_W-1]   chunk_in;
  logic [0:CHUNK_W-1]   chunk_out;

  // One shared part-select feeds every lane; the same base writes the result back.
  assign chunk_base = 8'(cnt_q) * 8'(CHUNK_W);
  assign chunk_in   = work_q[chunk_base +: CHUNK_W];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    aes_sbox u_sbox (
      .i_byte    (chunk_in[gi*8 +: 8]),
      .i_inverse (inv_q),
      .o_byte    (chunk_out[gi*8 +: 8])
    );
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    if (i_clear) begin
      state_d = SB_IDLE;
    end else begin
      case (state_q)
        SB_IDLE: begin
          if (bus.i_valid && ready_q) begin
            work_d  = bus.i_data;
            inv_d   = bus.i_inverse;
            cnt_d   = '0;
            state_d = SB_RUN;
          end
        end
        SB_RUN: begin
          work_d[chunk_base +: CHUNK_W] = chunk_out;
          if (cnt_q == CW'(N - 1)) begin
            state_d = SB_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        SB_DONE: begin
          if (bus.i_ready) begin
            state_d = SB_IDLE;
          end
        end
        default: state_d = SB_IDLE;
      endcase
    end
    // Outputs are decoded from the next state so they appear registered.
    ready_d = (state_d == SB_IDLE);
    valid_d = (state_d == SB_DONE);
    busy_d  = (state_d != SB_IDLE);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= SB_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_data  = work_q;

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// Five engines (LANES = 1, 2, 4, 8, 16) share one stimulus stream; results and
// latencies are compared against hand-computed vectors, plus corner sequences.
module tb_aes_sub_bytes_iter;
  import aes_pkg::*;

  localparam int NL = 5;
  localparam logic [127:0] SPEC_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] SPEC_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       tb_valid;
  logic       tb_ready;
  logic       tb_inv;
  aes_state_t tb_data;

  logic [NL-1:0] o_valid_a;
  logic [NL-1:0] o_ready_a;
  logic [NL-1:0] o_busy_a;
  aes_state_t    o_data_a [NL];

  aes_state_t res_a [NL];
  int         lat_a [NL];

  int n_cmp;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NL; gi++) begin : g_dut
    aes_sub_bytes_iter_if u_bus ();
    assign u_bus.i_valid   = tb_valid;
    assign u_bus.i_data    = tb_data;
    assign u_bus.i_inverse = tb_inv;
    assign u_bus.i_ready   = tb_ready;
    assign o_valid_a[gi]   = u_bus.o_valid;
    assign o_ready_a[gi]   = u_bus.o_ready;
    assign o_busy_a[gi]    = u_bus.o_busy;
    assign o_data_a[gi]    = u_bus.o_data;

    aes_sub_bytes_iter #(.LANES(1 << gi)) u_dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .i_clear   (clr),
      .bus       (u_bus)
    );
  end

  typedef struct {
    logic [127:0] din;
    logic         inv;
    logic         toggle;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_all_idle();
    int cyc;
    cyc = 0;
    while (o_ready_a != '1 && cyc < 40) begin
      step();
      cyc++;
    end
    chk("all_idle", 128'(o_ready_a), 128'h1f);
  endtask

  task automatic wait_valid2(output int cyc);
    cyc = 0;
    while (!o_valid_a[2] && cyc < 40) begin
      step();
      cyc++;
    end
    chk("lane4_valid_seen", 128'(o_valid_a[2]), 128'h1);
  endtask

  // Apply one block to all engines, capture each result and its latency.
  task automatic run_block(input logic [127:0] din, input logic inv, input logic toggle);
    logic [NL-1:0] got;
    int cyc;
    got = '0;
    for (int i = 0; i < NL; i++) begin
      lat_a[i] = -1;
      res_a[i] = '0;
    end
    tb_data  = din;
    tb_inv   = inv;
    tb_valid = 1'b1;
    tb_ready = 1'b1;
    step();
    tb_valid = 1'b0;
    tb_data  = ~din;
    cyc = 0;
    while (got != '1 && cyc < 40) begin
      step();
      cyc++;
      if (toggle) tb_inv = ~tb_inv;
      for (int i = 0; i < NL; i++) begin
        if (!got[i] && o_valid_a[i]) begin
          got[i]   = 1'b1;
          lat_a[i] = cyc;
          res_a[i] = o_data_a[i];
        end
      end
    end
    for (int i = 0; i < NL; i++) begin
      if (!got[i]) begin
        n_cmp++;
        n_bad++;
        $display("FAIL timeout_lanes%0d: got no o_valid expected o_valid within 40 cycles", 1 << i);
      end
    end
    step();
    chk("idle_after_block", 128'(o_ready_a), 128'h1f);
  endtask

  initial begin
    int cyc;
    n_cmp = 0;
    n_bad = 0;

    vecs[0] = '{SPEC_IN, 1'b0, 1'b0, SPEC_OUT};
    vecs[1] = '{128'h0, 1'b0, 1'b0, {16{8'h63}}};
    vecs[2] = '{128'h0, 1'b1, 1'b0, {16{8'h52}}};
    vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b1,
                128'h637c777bf26b6fc53001672bfed7ab76};
    vecs[4] = '{128'h637c777bf26b6fc53001672bfed7ab76, 1'b1, 1'b1,
                128'h000102030405060708090a0b0c0d0e0f};
    vecs[5] = '{{16{8'hff}}, 1'b0, 1'b0, {16{8'h16}}};
    vecs[6] = '{{16{8'hff}}, 1'b1, 1'b0, {16{8'h7d}}};

    rst_n    = 1'b0;
    clr      = 1'b0;
    tb_valid = 1'b0;
    tb_ready = 1'b1;
    tb_inv   = 1'b0;
    tb_data  = '0;

    // Reset values.
    #3;
    chk("rst_ready", 128'(o_ready_a), 128'h0);
    chk("rst_valid", 128'(o_valid_a), 128'h0);
    chk("rst_busy",  128'(o_busy_a),  128'h0);
    chk("rst_data",  o_data_a[2], 128'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 128'(o_ready_a), 128'h1f);
    chk("post_rst_valid", 128'(o_valid_a), 128'h0);

    // Table-driven vectors across all lane counts.
    for (int v = 0; v < 7; v++) begin
      run_block(vecs[v].din, vecs[v].inv, vecs[v].toggle);
      for (int l = 0; l < NL; l++) begin
        chk($sformatf("vec%0d_lanes%0d_data", v, 1 << l), res_a[l], vecs[v].exp);
        chk($sformatf("vec%0d_lanes%0d_latency", v, 1 << l), 128'(lat_a[l]), 128'(16 >> l));
      end
      $display("vec %0d: din=%h inv=%0d lanes4 out=%h lat=%0d", v, vecs[v].din, vecs[v].inv, res_a[2], lat_a[2]);
    end

    // Clear together with valid in IDLE: not accepted.
    clr      = 1'b1;
    tb_valid = 1'b1;
    tb_data  = SPEC_IN;
    step();
    clr      = 1'b0;
    tb_valid = 1'b0;
    chk("clr_valid_busy",  128'(o_busy_a),  128'h0);
    chk("clr_valid_ready", 128'(o_ready_a), 128'h1f);
    step();
    chk("clr_valid_no_out", 128'(o_valid_a), 128'h0);
    $display("seq clear+valid in idle: busy=%b ready=%b", o_busy_a, o_ready_a);

    // Backpressure: DONE held for 10 cycles with a stray valid pulse.
    tb_ready = 1'b0;
    tb_data  = SPEC_IN;
    tb_inv   = 1'b0;
    tb_valid = 1'b1;
    step();
    tb_valid = 1'b0;
    wait_valid2(cyc);
    chk("bp_data_first", o_data_a[2], SPEC_OUT);
    for (int k = 0; k < 10; k++) begin
      tb_valid = (k == 3);
      tb_data  = (k == 3) ? 128'h0 : SPEC_IN;
      step();
      chk($sformatf("bp%0d_data", k),  o_data_a[2], SPEC_OUT);
      chk($sformatf("bp%0d_ready", k), 128'(o_ready_a[2]), 128'h0);
      chk($sformatf("bp%0d_valid", k), 128'(o_valid_a[2]), 128'h1);
    end
    tb_valid = 1'b0;
    tb_ready = 1'b1;
    step();
    chk("bp_release_valid", 128'(o_valid_a[2]), 128'h0);
    chk("bp_release_ready", 128'(o_ready_a[2]), 128'h1);
    $display("seq backpressure: lanes4 out=%h ready=%b", o_data_a[2], o_ready_a[2]);
    wait_all_idle();

    // Clear on the second RUN cycle.
    tb_data  = SPEC_IN;
    tb_inv   = 1'b0;
    tb_valid = 1'b1;
    step();
    tb_valid = 1'b0;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_run_valid", 128'(o_valid_a[2]), 128'h0);
    chk("clr_run_ready", 128'(o_ready_a[2]), 128'h1);
    chk("clr_run_busy",  128'(o_busy_a[2]),  128'h0);
    chk("clr_run_all_ready", 128'(o_ready_a), 128'h1f);
    run_block(SPEC_IN, 1'b0, 1'b0);
    chk("clr_run_next_data", res_a[2], SPEC_OUT);
    chk("clr_run_next_lat",  128'(lat_a[2]), 128'd4);
    $display("seq clear in RUN: next block out=%h", res_a[2]);

    // Clear in DONE.
    tb_ready = 1'b0;
    tb_data  = SPEC_IN;
    tb_valid = 1'b1;
    step();
    tb_valid = 1'b0;
    wait_valid2(cyc);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_done_valid", 128'(o_valid_a[2]), 128'h0);
    chk("clr_done_ready", 128'(o_ready_a[2]), 128'h1);
    tb_ready = 1'b1;
    wait_all_idle();
    run_block(128'h0, 1'b1, 1'b0);
    chk("clr_done_next_data", res_a[2], {16{8'h52}});
    $display("seq clear in DONE: next block out=%h", res_a[2]);

    // Asynchronous reset in the middle of RUN.
    tb_data  = SPEC_IN;
    tb_inv   = 1'b0;
    tb_valid = 1'b1;
    step();
    tb_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 128'(o_valid_a), 128'h0);
    chk("midrst_busy",  128'(o_busy_a),  128'h0);
    chk("midrst_ready", 128'(o_ready_a), 128'h0);
    chk("midrst_data",  o_data_a[2], 128'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_ready_after", 128'(o_ready_a), 128'h1f);
    run_block(SPEC_IN, 1'b0, 1'b0);
    chk("midrst_next_data", res_a[2], SPEC_OUT);
    chk("midrst_next_data_l1", res_a[0], SPEC_OUT);
    $display("seq reset mid-RUN: next block out=%h", res_a[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_sub_bytes_iter.md
# aes_sub_bytes_iter

- Parametrised, iterative AES SubBytes / InvSubBytes engine.
- Substitutes a 128-bit state through `LANES` S-box instances per cycle. A block takes 16/`LANES` cycles, so area can be traded against throughput.
- Adds a valid/ready handshake on both sides, a runtime forward/inverse mode select, and a synchronous clear.
- Sits between AddRoundKey and ShiftRows in the round datapath and in the key-expansion SubWord path.

## Interface
- `LANES`, default 4: S-box instances per cycle. Legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.
- `i_clock`  in  1  rising-edge clock
- `i_reset_n`  in  1  asynchronous, active-low reset
- `i_clear`  in  1  synchronous abort; returns to IDLE and discards the block in flight
- `i_valid`  in  1  input block valid
- `o_ready`  out  1  engine can accept a block (high only in IDLE)
- `i_data`  in  [0:127]  input state; byte k = bits [8k:8k+7], byte 0 = bits [0:7]
- `i_inverse`  in  1  0 = forward S-box, 1 = inverse S-box; sampled at acceptance
- `o_valid`  out  1  result valid; held until consumed
- `i_ready`  in  1  downstream accepts the result
- `o_data`  out  [0:127]  substituted state, same byte order as `i_data`
- `o_busy`  out  1  high in RUN or DONE

## Operation
- Constants:
  - N = 16/`LANES` chunks.
  - Chunk c covers bytes c·`LANES` … c·`LANES`+`LANES`−1.
  - Chunk counter width is max(1, clog2(N)).
- FSM states are IDLE, RUN and DONE.
  - IDLE: `o_ready`=1. On `i_valid`, load the working register from `i_data`, latch `i_inverse`, clear the chunk counter, go to RUN.
  - RUN: each cycle, replace chunk c in place with its S-box output (forward or inverse per the latched mode) and increment c. After chunk N−1 is written, go to DONE.
  - DONE: `o_valid`=1 and `o_data` is stable. On `i_ready`, go to IDLE.
- `o_data` is driven directly from the working register. Its value is defined only while `o_valid`=1.
- While in RUN or DONE, `i_data` and `i_inverse` are ignored.
- `i_clear` has priority over every transition. Next state is IDLE, `o_valid` drops the following cycle, and the working register is left unchanged.
- `i_clear` together with `i_valid` in IDLE: the block is not accepted.
- `LANES`=16 gives N=1. The counter is present but unused; exactly one RUN cycle occurs.
- The mode cannot change mid-block, because the latched copy is used throughout.

## Timing
- Reset values, applied asynchronously on `i_reset_n`=0:
  - State IDLE.
  - `o_ready`=1 after reset deassertion (0 while reset is asserted).
  - `o_valid`=0, `o_busy`=0.
  - Working register all zeros, so `o_data`=0; counter=0; latched mode=0.
- Acceptance edge E0 (IDLE, `i_valid`=1).
- Chunks are written on edges E1…EN.
- `o_valid` rises after EN, i.e. N cycles after acceptance.
- With `i_ready` held high, `o_valid` is high for exactly 1 cycle. The next acceptance is possible one cycle later, so the minimum block period is N+2 cycles.
- `i_ready` held low: DONE persists indefinitely and `o_data` does not change.
- No combinational path from `i_valid`/`i_ready` to `o_ready`/`o_valid`. All outputs are registered or decoded from state only.
- Reset asserted mid-block: the block is lost and all outputs return to reset values immediately.

## Structure
- Shared package `aes_pkg` contains:
  - `aes_byte_t` (8-bit) and `aes_state_t` (128-bit) types.
  - `AES_SBOX_FWD[0:255]` and `AES_SBOX_INV[0:255]` constant tables.
  - `AES_BYTES` = 16.
- Sub-module `aes_sbox`: purely combinational. Inputs are one byte and the inverse flag; output is the substituted byte. It is instantiated `LANES` times.
- Chunk select and write-back use an indexed part-select driven by the counter. There is no duplicate full-width mux per lane.

## Test plan
- `LANES`=4, forward, `i_data`=0x193de3bea0f4e22b9ac68d2ae9f84808 → `o_data`=0xd42711aee0bf98f1b8b45de51e415230; `o_valid` rises 4 cycles after acceptance.
- `LANES`=1, 2, 8 and 16, all-zero input:
  - Forward → 0x63 repeated ×16.
  - Inverse → 0x52 repeated ×16.
  - Latency is 16, 8, 2 and 1 cycles respectively.
- Round trip: forward result of 0x000102…0f fed back in with `i_inverse`=1 returns 0x000102…0f. Toggling `i_inverse` during RUN has no effect on the result.
- Backpressure: hold `i_ready`=0 for 10 cycles after `o_valid`.
  - `o_data` stays stable, `o_ready`=0, and a pulse on `i_valid` is ignored.
  - Releasing `i_ready` gives IDLE the next cycle.
- `i_clear` asserted on the second RUN cycle, and separately in DONE:
  - `o_valid` stays or drops to 0 and `o_ready`=1 the next cycle.
  - A following block completes correctly.
- `i_reset_n` pulsed low mid-RUN: `o_valid`=0, `o_busy`=0, `o_data`=0 immediately; the next accepted block is processed correctly.
